data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_pkg.sv | 14 +
 rtl/data_memory_responder_store_buffer.sv | 72 +++++++
 rtl/data_memory_responder.sv | 79 +++++++
 tb/tb_data_memory_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and default geometry for the data-memory responder.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_DEPTH_LOG2 = 10;
    localparam int MEM_WB_DEPTH   = 4;

    typedef struct packed {
        logic [MEM_DEPTH_LOG2-1:0] index;
        logic [MEM_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/data_memory_responder_store_buffer.sv
// Posted-store FIFO with a youngest-match search port for load forwarding.
module store_buffer
    import mem_pkg::*;
#(
    parameter int IDX_W  = MEM_DEPTH_LOG2,
    parameter int DATA_W = MEM_DATA_WIDTH,
    parameter int DEPTH  = MEM_WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [IDX_W-1:0]  push_index,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [IDX_W-1:0]  head_index,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    input  logic [IDX_W-1:0]  search_index,
    output logic              search_hit,
    output logic [DATA_W-1:0] search_data
);

    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr]  <= push_index;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign head_index = idx_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (idx_q[slot] == search_index)) begin
                search_hit  = 1'b1;
                search_data = data_q[slot];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word array behind a posted write buffer, loads forward from it.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int WB_DEPTH   = MEM_WB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       address_rw,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        write_enable,
    input  logic                        read_enable,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        stall,
    output logic                        wb_empty,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);

    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] index;
    logic [DEPTH_LOG2-1:0] head_index;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_hit;
    logic                  push;
    logic                  pop;

    assign index = address_rw[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^address_rw[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // No bypass: a full buffer stalls even on a cycle it also drains.
    assign stall    = write_enable && (wb_count == CNT_W'(WB_DEPTH));
    assign push     = write_enable && !stall;
    assign pop      = (wb_count != '0) && !read_enable;
    assign wb_empty = (wb_count == '0);

    store_buffer #(
        .IDX_W  (DEPTH_LOG2),
        .DATA_W (DATA_WIDTH),
        .DEPTH  (WB_DEPTH)
    ) u_store_buffer (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_index   (index),
        .push_data    (data_in),
        .pop          (pop),
        .head_index   (head_index),
        .head_data    (head_data),
        .count        (wb_count),
        .search_index (index),
        .search_hit   (fwd_hit),
        .search_data  (fwd_data)
    );

    // Single-port array: written only on cycles without a load.
    always_ff @(posedge clk) begin
        if (pop) mem_q[head_index] <= head_data;
    end

    always_comb begin
        data_out = '0;
        if (read_enable && rst) begin
            data_out = fwd_hit ? fwd_data : mem_q[index];
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed plus randomized bench for data_memory_responder against a queue/array model.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address_rw;
    logic [15:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] data_out;
    logic        stall;
    logic        wb_empty;
    logic [2:0]  wb_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] arr[int];

    data_memory_responder dut (
        .clk          (clk),
        .rst          (rst),
        .address_rw   (address_rw),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .stall        (stall),
        .wb_empty     (wb_empty),
        .wb_count     (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input logic we, input logic re, input logic [15:0] addr,
                        input logic [15:0] din, output logic stalled);
        int          idx;
        logic [15:0] exp_do;
        logic        known;
        logic        exp_stall;
        write_enable = we;
        read_enable  = re;
        address_rw   = addr;
        data_in      = din;
        #1;
        idx       = int'(addr) % 1024;
        exp_stall = we && (mq.size() == 4);
        known     = 1'b1;
        exp_do    = 16'h0;
        if (re) begin
            known = 1'b0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].idx == idx) begin
                    exp_do = mq[i].data;
                    known  = 1'b1;
                    break;
                end
            end
            if (!known && arr.exists(idx)) begin
                exp_do = arr[idx];
                known  = 1'b1;
            end
        end
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("wb_count", 32'(wb_count), 32'(mq.size()));
        chk("wb_empty", 32'(wb_empty), 32'(mq.size() == 0));
        if (known) chk("data_out", 32'(data_out), 32'(exp_do));
        stalled = exp_stall;
        @(posedge clk);
        if (!re && mq.size() != 0) begin
            arr[mq[0].idx] = mq[0].data;
            void'(mq.pop_front());
        end
        if (we && !exp_stall) mq.push_back('{idx, din});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, st);
    endtask

    initial begin
        logic        st;
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] pool [8];
        pool = '{16'h0005, 16'h0010, 16'h0020, 16'h0030, 16'h0041, 16'h03FF, 16'h0100, 16'h02AA};

        rst = 1'b0;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        address_rw   = 16'h0010;
        data_in      = 16'h0;
        #3;
        chk("rst_wb_count", 32'(wb_count), 32'd0);
        chk("rst_wb_empty", 32'(wb_empty), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Preload every address the bench will read.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, pool[k], 16'(k * 16'h0111 + 1), st);
        idle(3);

        // Forwarding from youngest entry, then drain into the array.
        step(1'b1, 1'b1, 16'h0010, 16'h00A5, st);
        step(1'b1, 1'b1, 16'h0010, 16'h1234, st);
        step(1'b0, 1'b1, 16'h0010, 16'h0, st);
        idle(2);
        step(1'b0, 1'b1, 16'h0010, 16'h0, st);
        chk("fwd_array_value", 32'(data_out), 32'h1234);

        // Full buffer stalls the fifth store; requester holds it until accepted.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, pool[k], 16'hC000 + 16'(k), st);
        chk("fifth_store_stalled", 32'(st), 32'd1);
        for (int k = 0; k < 4 && st; k++) step(1'b1, 1'b0, pool[4], 16'hC004, st);
        idle(6);
        step(1'b0, 1'b1, pool[4], 16'h0, st);
        chk("stalled_store_landed", 32'(data_out), 32'hC004);

        // Simultaneous enqueue and drain keeps the count steady, FIFO order preserved.
        step(1'b1, 1'b1, 16'h0030, 16'hD000, st);
        step(1'b1, 1'b1, 16'h0030, 16'hD001, st);
        for (int k = 2; k < 6; k++) step(1'b1, 1'b0, 16'h0030, 16'hD000 + 16'(k), st);
        idle(3);
        step(1'b0, 1'b1, 16'h0030, 16'h0, st);
        chk("fifo_order_last", 32'(data_out), 32'hD005);

        // Aliasing: upper address bits ignored.
        step(1'b1, 1'b0, 16'h0405, 16'hBEEF, st);
        step(1'b0, 1'b1, 16'h0005, 16'h0, st);
        chk("alias_read", 32'(data_out), 32'hBEEF);

        // Same-cycle load and store of one index returns the old value.
        step(1'b1, 1'b0, 16'h0020, 16'h0001, st);
        idle(2);
        step(1'b1, 1'b1, 16'h0020, 16'h0002, st);
        step(1'b0, 1'b1, 16'h0020, 16'h0, st);
        chk("same_cycle_new", 32'(data_out), 32'h0002);
        idle(2);

        // Reset mid-stream discards buffered stores but keeps the array.
        step(1'b1, 1'b1, 16'h0041, 16'hE001, st);
        step(1'b1, 1'b1, 16'h0100, 16'hE002, st);
        step(1'b1, 1'b1, 16'h02AA, 16'hE003, st);
        write_enable = 1'b1;
        read_enable  = 1'b1;
        address_rw   = 16'h0041;
        #2 rst = 1'b0;
        #1;
        chk("midrst_wb_count", 32'(wb_count), 32'd0);
        chk("midrst_wb_empty", 32'(wb_empty), 32'd1);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 16'h0041, 16'h0, st);
        step(1'b0, 1'b1, 16'h0100, 16'h0, st);
        step(1'b0, 1'b1, 16'h02AA, 16'h0, st);

        // Randomized traffic; a stalled store is held until accepted.
        st   = 1'b0;
        we   = 1'b0;
        addr = 16'h0;
        din  = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!st) begin
                we   = ($urandom_range(0, 1) == 1);
                addr = {6'($urandom()), pool[$urandom_range(0, 7)][9:0]};
                din  = 16'($urandom());
            end
            re = ($urandom_range(0, 2) != 0);
            if (!we) addr = {6'($urandom()), pool[$urandom_range(0, 7)][9:0]};
            step(we, re, addr, din, st);
        end
        idle(6);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, pool[k], 16'h0, st);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
